// File: rtl/hazard_unit.sv
// Stall, flush and operand-forwarding control for a five-stage pipeline with a multi-cycle mul/div unit.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_usesRt,
  input  logic [4:0]  EX_reg,
  input  logic [4:0]  MEM_reg,
  input  logic        EX_regWr,
  input  logic        EX_memRd,
  input  logic        MEM_regWr,
  input  logic        EX_mdStart,
  input  logic        EX_branchTaken,
  input  logic        mem_busy,
  output logic        PC_wrEn,
  output logic        IFID_wrEn,
  output logic        IDEX_wrEn,
  output logic        EXMEM_wrEn,
  output logic        MEMWB_wrEn,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        pc_sel,
  output logic [1:0]  fwdA_sel,
  output logic [1:0]  fwdB_sel,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned PERF_W = 16;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {RUN, MD_BUSY, FREEZE} state_e;

  state_e             state_q, state_d, eff_state;
  logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic [FWD_W-1:0]   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [FWD_W-1:0]   fwd_a_calc, fwd_b_calc;
  logic               load_use;

  always_comb begin
    load_use = EX_memRd & EX_regWr & (EX_reg != '0) &
               ((EX_reg == ID_rs) | (ID_usesRt & (EX_reg == ID_rt)));
  end

  // FREEZE remembers its return state implicitly: a nonzero md counter means MD_BUSY.
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    PC_wrEn     = 1'b1;
    IFID_wrEn   = 1'b1;
    IDEX_wrEn   = 1'b1;
    EXMEM_wrEn  = 1'b1;
    MEMWB_wrEn  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    pc_sel      = 1'b0;
    eff_state   = state_q;
    if (state_q == FREEZE) begin
      eff_state = (md_cnt_q != '0) ? MD_BUSY : RUN;
    end
    if (reset) begin
      state_d  = RUN;
      md_cnt_d = '0;
    end else if (mem_busy) begin
      PC_wrEn    = 1'b0;
      IFID_wrEn  = 1'b0;
      IDEX_wrEn  = 1'b0;
      EXMEM_wrEn = 1'b0;
      MEMWB_wrEn = 1'b0;
      state_d    = FREEZE;
    end else begin
      state_d = eff_state;
      case (eff_state)
        MD_BUSY: begin
          if (md_cnt_q <= CNT_W'(1)) begin
            md_cnt_d = '0;
            state_d  = RUN;
          end else begin
            PC_wrEn     = 1'b0;
            IFID_wrEn   = 1'b0;
            IDEX_wrEn   = 1'b0;
            EXMEM_flush = 1'b1;
            md_cnt_d    = md_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (EX_mdStart) begin
            PC_wrEn     = 1'b0;
            IFID_wrEn   = 1'b0;
            IDEX_wrEn   = 1'b0;
            EXMEM_flush = 1'b1;
            md_cnt_d    = CNT_W'(MD_LATENCY - 1);
            state_d     = MD_BUSY;
          end else if (EX_branchTaken) begin
            pc_sel     = 1'b1;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (load_use) begin
            PC_wrEn    = 1'b0;
            IFID_wrEn  = 1'b0;
            IDEX_flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Operand selects for the instruction entering EX; EX/MEM beats MEM/WB, r0 is never forwarded.
  always_comb begin
    fwd_a_calc = FWD_RF;
    if (EX_regWr && (EX_reg != '0) && (EX_reg == ID_rs)) begin
      fwd_a_calc = FWD_EXMEM;
    end else if (MEM_regWr && (MEM_reg != '0) && (MEM_reg == ID_rs)) begin
      fwd_a_calc = FWD_MEMWB;
    end
    fwd_b_calc = FWD_RF;
    if (ID_usesRt) begin
      if (EX_regWr && (EX_reg != '0) && (EX_reg == ID_rt)) begin
        fwd_b_calc = FWD_EXMEM;
      end else if (MEM_regWr && (MEM_reg != '0) && (MEM_reg == ID_rt)) begin
        fwd_b_calc = FWD_MEMWB;
      end
    end
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (IDEX_flush) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else if (IDEX_wrEn) begin
      fwd_a_d = fwd_a_calc;
      fwd_b_d = fwd_b_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign fwdA_sel = fwd_a_q;
  assign fwdB_sel = fwd_b_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_wrEn && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (IFID_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed, table-driven bench for hazard_unit (default MD_LATENCY of 4).
module tb_hazard_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_reg, MEM_reg;
  logic        ID_usesRt, EX_regWr, EX_memRd, MEM_regWr;
  logic        EX_mdStart, EX_branchTaken, mem_busy;
  logic        PC_wrEn, IFID_wrEn, IDEX_wrEn, EXMEM_wrEn, MEMWB_wrEn;
  logic        IFID_flush, IDEX_flush, EXMEM_flush, pc_sel;
  logic [1:0]  fwdA_sel, fwdB_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Control word order: PC, IFID, IDEX, EXMEM, MEMWB wrEn; IFID, IDEX, EXMEM flush; pc_sel.
  localparam logic [8:0] C_NORM = 9'b111110000;
  localparam logic [8:0] C_LU   = 9'b001110100;
  localparam logic [8:0] C_BR   = 9'b111111101;
  localparam logic [8:0] C_MD   = 9'b000110010;
  localparam logic [8:0] C_FRZ  = 9'b000000000;

`ifdef HAZARD_PERF_EN
  localparam logic [15:0] EXP_SAT = 16'hFFFF;
  localparam logic [15:0] EXP_ONE = 16'h0001;
`else
  localparam logic [15:0] EXP_SAT = 16'h0000;
  localparam logic [15:0] EXP_ONE = 16'h0000;
`endif

  typedef struct {
    logic       rst, mb, md, br;
    logic [4:0] exr;
    logic       exw, exl;
    logic [4:0] mr;
    logic       mw;
    logic [4:0] rs, rt;
    logic       ut;
    logic [8:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl[16];

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_usesRt(ID_usesRt),
    .EX_reg(EX_reg), .MEM_reg(MEM_reg),
    .EX_regWr(EX_regWr), .EX_memRd(EX_memRd), .MEM_regWr(MEM_regWr),
    .EX_mdStart(EX_mdStart), .EX_branchTaken(EX_branchTaken), .mem_busy(mem_busy),
    .PC_wrEn(PC_wrEn), .IFID_wrEn(IFID_wrEn), .IDEX_wrEn(IDEX_wrEn),
    .EXMEM_wrEn(EXMEM_wrEn), .MEMWB_wrEn(MEMWB_wrEn),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
    .pc_sel(pc_sel), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, mb, md, br, input logic [4:0] exr,
                              input logic exw, exl, input logic [4:0] mr, input logic mw,
                              input logic [4:0] rs, rt, input logic ut,
                              input logic [8:0] ctrl, input logic [1:0] fa, fb);
    vec_t v;
    v.rst = rst; v.mb = mb; v.md = md; v.br = br;
    v.exr = exr; v.exw = exw; v.exl = exl; v.mr = mr; v.mw = mw;
    v.rs = rs; v.rt = rt; v.ut = ut; v.ctrl = ctrl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; control checked mid-cycle, selects after the edge.
  task automatic run(input vec_t v, input string name);
    reset = v.rst; mem_busy = v.mb; EX_mdStart = v.md; EX_branchTaken = v.br;
    EX_reg = v.exr; EX_regWr = v.exw; EX_memRd = v.exl;
    MEM_reg = v.mr; MEM_regWr = v.mw;
    ID_rs = v.rs; ID_rt = v.rt; ID_usesRt = v.ut;
    #4;
    chk({name, " ctrl"}, 16'({PC_wrEn, IFID_wrEn, IDEX_wrEn, EXMEM_wrEn, MEMWB_wrEn,
                              IFID_flush, IDEX_flush, EXMEM_flush, pc_sel}), 16'(v.ctrl));
    @(posedge clk);
    #1;
    chk({name, " fwdA"}, 16'(fwdA_sel), 16'(v.fa));
    chk({name, " fwdB"}, 16'(fwdB_sel), 16'(v.fb));
  endtask

  initial begin
    reset = 1'b1; mem_busy = 1'b0; EX_mdStart = 1'b0; EX_branchTaken = 1'b0;
    EX_reg = '0; EX_regWr = 1'b0; EX_memRd = 1'b0; MEM_reg = '0; MEM_regWr = 1'b0;
    ID_rs = '0; ID_rt = '0; ID_usesRt = 1'b0;

    //            rst mb md br exr exw exl mr mw rs rt ut ctrl   fa fb
    tbl[0]  = mk(0, 0, 0, 0, 3, 1, 0, 4, 1, 1, 2, 1, C_NORM, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 5, 1, 0, 5, 1, 5, 6, 1, C_NORM, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, C_NORM, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 7, 1, 0, 9, 1, 9, 7, 1, C_NORM, 2, 1);
    tbl[4]  = mk(0, 0, 0, 0, 7, 1, 0, 9, 1, 1, 7, 0, C_NORM, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 9, 0, 0, 9, 1, 9, 9, 1, C_NORM, 2, 2);
    tbl[6]  = mk(0, 0, 0, 0, 8, 1, 1, 2, 1, 8, 3, 1, C_LU,   0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 8, 1, 8, 3, 1, C_NORM, 2, 0);
    tbl[8]  = mk(0, 0, 0, 0, 8, 1, 1, 2, 1, 1, 8, 1, C_LU,   0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 8, 1, 1, 2, 1, 1, 8, 0, C_NORM, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, C_NORM, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 8, 0, 1, 8, 1, 8, 8, 1, C_NORM, 2, 2);
    tbl[12] = mk(0, 0, 0, 1, 8, 1, 1, 2, 0, 8, 3, 1, C_BR,   0, 0);
    tbl[13] = mk(0, 0, 0, 1, 5, 1, 0, 0, 0, 5, 5, 1, C_BR,   0, 0);
    tbl[14] = mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 5, 1, C_NORM, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 5, 1, 0, 3, 1, 3, 5, 1, C_NORM, 2, 1);

    @(posedge clk);
    #1;
    // Reset with mem_busy high still shows normal control values.
    run(mk(1, 1, 1, 0, 5, 1, 0, 5, 1, 5, 5, 1, C_NORM, 0, 0), "reset");
    chk("reset stall_cnt", stall_cnt, 16'h0000);
    chk("reset flush_cnt", flush_cnt, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      run(tbl[i], $sformatf("tbl%0d", i));
    end

    // Multiply/divide: three stall cycles, selects held until IDEX advances.
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "md0");
    run(mk(0, 0, 1, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   0, 0), "md1");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   0, 0), "md2");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   0, 0), "md3");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_NORM, 1, 0), "md4");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "md5");

    // mem_busy for two cycles while the md counter reads 2.
    run(mk(0, 0, 1, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   0, 0), "frz1");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   0, 0), "frz2");
    run(mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_FRZ,  0, 0), "frz3");
    run(mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_FRZ,  0, 0), "frz4");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   0, 0), "frz5");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_NORM, 1, 0), "frz6");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "frz7");

    // mem_busy overrides md start, branch and load-use; RUN resumes afterward.
    run(mk(0, 1, 1, 1, 8, 1, 1, 0, 0, 8, 0, 0, C_FRZ,  0, 0), "busy1");
    run(mk(0, 0, 0, 0, 8, 1, 1, 0, 0, 8, 0, 0, C_LU,   0, 0), "busy2");
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "busy3");

    // Reset in the middle of MD_BUSY abandons it.
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_NORM, 1, 0), "rmd0");
    run(mk(0, 0, 1, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   1, 0), "rmd1");
    run(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_MD,   1, 0), "rmd2");
    run(mk(1, 1, 0, 0, 5, 1, 0, 0, 0, 5, 0, 0, C_NORM, 0, 0), "rmd3");
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "rmd4");

    // Performance counters: long freeze saturates, branch counts one flush.
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "prst");
    mem_busy = 1'b1;
    reset = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat stall_cnt", stall_cnt, EXP_SAT);
    chk("sat flush_cnt", flush_cnt, 16'h0000);
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0), "prst2");
    chk("cleared stall_cnt", stall_cnt, 16'h0000);
    run(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_BR,   0, 0), "pbr");
    chk("branch flush_cnt", flush_cnt, EXP_ONE);
    chk("branch stall_cnt", stall_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
